ad_ip_jesd204_tpl_adc_capture_ctrl: RTL and testbench

- Capture sequencer between the TPL ADC core output (adc_valid/adc_data) and the DMA write port, all in the link_clk domain.
- Gates the sample stream into bounded, trigger-aligned bursts of a programmed beat count, or into a continuous stream.
- Reports busy/armed/done/overflow status and the captured beat count to the regmap, which synchronizes them.

---
 rtl/ad_ip_jesd204_tpl_adc_capture_ctrl_if.sv | 49 ++++
 rtl/ad_ip_jesd204_tpl_adc_capture_ctrl.sv | 157 +++++++++++++++
 tb/tb_ad_ip_jesd204_tpl_adc_capture_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ad_ip_jesd204_tpl_adc_capture_ctrl_if.sv
// rtl/ad_ip_jesd204_tpl_adc_capture_ctrl_if.sv - control, sample stream and status bundle for the ADC capture sequencer
//
// Purpose: groups every non-clock signal of the capture sequencer.
// Ports (signals):
//   ctrl_arm/ctrl_abort/ctrl_trig_mode/ctrl_length - capture control from the regmap
//   ext_trig                                       - trigger level, synchronous to link clock
//   enable/adc_valid_in/adc_data_in/adc_dovf_in    - TPL core stream and DMA overflow
//   adc_valid_out/adc_data_out                     - gated stream to the DMA write port
//   status_*                                       - registered status back to the regmap
// Modports: master drives control and the input stream; slave is the sequencer.

interface ad_ip_jesd204_tpl_adc_capture_ctrl_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 128,
  parameter int LENGTH_WIDTH = 16
);

  logic                    ctrl_arm;
  logic                    ctrl_abort;
  logic                    ctrl_trig_mode;
  logic [LENGTH_WIDTH-1:0] ctrl_length;
  logic                    ext_trig;
  logic [NUM_CHANNELS-1:0] enable;
  logic [NUM_CHANNELS-1:0] adc_valid_in;
  logic [DATA_WIDTH-1:0]   adc_data_in;
  logic                    adc_dovf_in;
  logic [NUM_CHANNELS-1:0] adc_valid_out;
  logic [DATA_WIDTH-1:0]   adc_data_out;
  logic                    status_busy;
  logic                    status_armed;
  logic                    status_done;
  logic                    status_ovf;
  logic [LENGTH_WIDTH-1:0] status_beat_count;

  modport master (
    output ctrl_arm, ctrl_abort, ctrl_trig_mode, ctrl_length, ext_trig,
           enable, adc_valid_in, adc_data_in, adc_dovf_in,
    input  adc_valid_out, adc_data_out, status_busy, status_armed,
           status_done, status_ovf, status_beat_count
  );

  modport slave (
    input  ctrl_arm, ctrl_abort, ctrl_trig_mode, ctrl_length, ext_trig,
           enable, adc_valid_in, adc_data_in, adc_dovf_in,
    output adc_valid_out, adc_data_out, status_busy, status_armed,
           status_done, status_ovf, status_beat_count
  );

endinterface

// File: rtl/ad_ip_jesd204_tpl_adc_capture_ctrl.sv
// rtl/ad_ip_jesd204_tpl_adc_capture_ctrl.sv - trigger-aligned bounded/continuous ADC capture sequencer
//
// Purpose: gates the TPL ADC sample stream into bursts of a programmed beat
// count (or a continuous stream) starting immediately or on an ext_trig
// rising edge, and reports busy/armed/done/overflow/beat count.
// Ports:
//   clk - link clock
//   rst - asynchronous reset, active-high
//   bus - slave side of ad_ip_jesd204_tpl_adc_capture_ctrl_if (control,
//         sample stream in/out, status)

module ad_ip_jesd204_tpl_adc_capture_ctrl #(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 128,
  parameter int LENGTH_WIDTH = 16
) (
  input logic                                 clk,
  input logic                                 rst,
  ad_ip_jesd204_tpl_adc_capture_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;

  logic [LENGTH_WIDTH-1:0] r_length;
  logic [LENGTH_WIDTH-1:0] r_beat_count;
  logic                    r_ext_trig_d;
  logic                    r_busy;
  logic                    r_armed;
  logic                    r_done;
  logic                    r_ovf;
  logic [NUM_CHANNELS-1:0] r_valid_out;
  logic [DATA_WIDTH-1:0]   r_data_out;

  logic                    w_beat;
  logic                    w_capture_beat;
  logic                    w_trig_edge;
  logic                    w_arm_ok;
  logic                    w_final_beat;
  logic [LENGTH_WIDTH-1:0] w_count_inc;
  logic                    w_busy_next;
  logic                    w_armed_next;

  assign w_beat         = |(bus.adc_valid_in & bus.enable);
  assign w_capture_beat = (r_state == ST_CAPTURE) && w_beat;
  assign w_trig_edge    = bus.ext_trig && !r_ext_trig_d;

  // Arm is only accepted from a quiescent state and never alongside abort.
  assign w_arm_ok = bus.ctrl_arm && !bus.ctrl_abort &&
                    ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // Count saturates so continuous captures never wrap back to small values.
  assign w_count_inc = (&r_beat_count) ? r_beat_count
                                       : r_beat_count + LENGTH_WIDTH'(1);

  // Length 0 means continuous, so only a nonzero length can complete.
  assign w_final_beat = w_capture_beat && (r_length != '0) &&
                        (w_count_inc == r_length);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (bus.ctrl_arm) begin
          w_state_next = bus.ctrl_trig_mode ? ST_ARMED : ST_CAPTURE;
        end
      end
      ST_ARMED: begin
        if (w_trig_edge) begin
          w_state_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (w_final_beat) begin
          w_state_next = ST_DONE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (bus.ctrl_abort) begin
      w_state_next = ST_IDLE;
    end
  end

  // Output decode from the next state so the registered flags line up
  // with the state register.
  always_comb begin
    w_busy_next  = (w_state_next == ST_ARMED) || (w_state_next == ST_CAPTURE);
    w_armed_next = (w_state_next == ST_ARMED);
  end

  // Datapath and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ext_trig_d <= 1'b0;
      r_length     <= '0;
      r_beat_count <= '0;
      r_busy       <= 1'b0;
      r_armed      <= 1'b0;
      r_done       <= 1'b0;
      r_ovf        <= 1'b0;
      r_valid_out  <= '0;
      r_data_out   <= '0;
    end else begin
      r_ext_trig_d <= bus.ext_trig;
      r_data_out   <= bus.adc_data_in;
      // Gated on the current state: a beat in the trigger-edge cycle is
      // dropped, and the final beat of a burst is still forwarded.
      r_valid_out  <= (r_state == ST_CAPTURE) ? (bus.adc_valid_in & bus.enable) : '0;
      r_busy       <= w_busy_next;
      r_armed      <= w_armed_next;

      if (w_arm_ok) begin
        r_length     <= bus.ctrl_length;
        r_beat_count <= '0;
        r_done       <= 1'b0;
        r_ovf        <= 1'b0;
      end else begin
        if (w_capture_beat) begin
          r_beat_count <= w_count_inc;
        end
        if (w_final_beat && !bus.ctrl_abort) begin
          r_done <= 1'b1;
        end
        if ((r_state == ST_CAPTURE) && bus.adc_dovf_in) begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  assign bus.adc_valid_out     = r_valid_out;
  assign bus.adc_data_out      = r_data_out;
  assign bus.status_busy       = r_busy;
  assign bus.status_armed      = r_armed;
  assign bus.status_done       = r_done;
  assign bus.status_ovf        = r_ovf;
  assign bus.status_beat_count = r_beat_count;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_capture_ctrl.sv
// tb/tb_ad_ip_jesd204_tpl_adc_capture_ctrl.sv - self-checking bench for the ADC capture sequencer
`timescale 1ns/1ps

module tb_ad_ip_jesd204_tpl_adc_capture_ctrl;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  ad_ip_jesd204_tpl_adc_capture_ctrl_if #(
    .NUM_CHANNELS(4), .DATA_WIDTH(128), .LENGTH_WIDTH(16)
  ) bus_if ();

  ad_ip_jesd204_tpl_adc_capture_ctrl #(
    .NUM_CHANNELS(4), .DATA_WIDTH(128), .LENGTH_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        arm;
    logic        abort;
    logic        tmode;
    logic        trig;
    logic        dovf;
    logic [15:0] len;
    logic [3:0]  en;
    logic [3:0]  vin;
    logic [3:0]  e_vout;
    logic        e_busy;
    logic        e_armed;
    logic        e_done;
    logic        e_ovf;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [127:0] mk_data(input int i);
    logic [31:0] w;
    w = 32'hC0DE0000 + i;
    return {w, ~w, w ^ 32'h5A5A5A5A, w};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input logic arm, input logic abort, input logic tmode,
                      input logic trig, input logic dovf, input logic [15:0] len,
                      input logic [3:0] en, input logic [3:0] vin,
                      input logic [127:0] data);
    bus_if.ctrl_arm       = arm;
    bus_if.ctrl_abort     = abort;
    bus_if.ctrl_trig_mode = tmode;
    bus_if.ext_trig       = trig;
    bus_if.adc_dovf_in    = dovf;
    bus_if.ctrl_length    = len;
    bus_if.enable         = en;
    bus_if.adc_valid_in   = vin;
    bus_if.adc_data_in    = data;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string tag, input logic [3:0] vout, input logic busy,
                            input logic armed, input logic done, input logic ovf,
                            input logic [15:0] cnt);
    chk({tag, "_vout"},  {124'd0, bus_if.adc_valid_out}, {124'd0, vout});
    chk({tag, "_busy"},  {127'd0, bus_if.status_busy},   {127'd0, busy});
    chk({tag, "_armed"}, {127'd0, bus_if.status_armed},  {127'd0, armed});
    chk({tag, "_done"},  {127'd0, bus_if.status_done},   {127'd0, done});
    chk({tag, "_ovf"},   {127'd0, bus_if.status_ovf},    {127'd0, ovf});
    chk({tag, "_cnt"},   {112'd0, bus_if.status_beat_count}, {112'd0, cnt});
  endtask

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    logic cap;
    logic done;
    logic [3:0] vin;
    logic [3:0] ev;

    n_pass  = 0;
    n_total = 0;

    // Reset state
    rst = 1'b1;
    bus_if.ctrl_arm = 0; bus_if.ctrl_abort = 0; bus_if.ctrl_trig_mode = 0;
    bus_if.ctrl_length = 0; bus_if.ext_trig = 0; bus_if.enable = 0;
    bus_if.adc_valid_in = 0; bus_if.adc_data_in = '1; bus_if.adc_dovf_in = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_status("reset", 4'h0, 0, 0, 0, 0, 16'h0);
    chk("reset_data", bus_if.adc_data_out, 128'h0);
    rst = 1'b0;

    // arm abort tmode trig dovf len en vin | vout busy armed done ovf cnt
    tbl.push_back('{1,0,0,0,0,16'd8,4'hF,4'hF, 4'h0,1,0,0,0,16'd0});
    tbl.push_back('{0,0,0,0,0,16'd0,4'hF,4'hF, 4'hF,1,0,0,0,16'd1});
    tbl.push_back('{0,0,0,0,0,16'd0,4'hF,4'hF, 4'hF,1,0,0,0,16'd2});
    tbl.push_back('{0,0,0,0,1,16'd0,4'hF,4'hF, 4'hF,1,0,0,1,16'd3});
    tbl.push_back('{0,0,0,0,0,16'd0,4'hF,4'hF, 4'hF,1,0,0,1,16'd4});
    tbl.push_back('{0,0,0,0,0,16'd0,4'hF,4'hF, 4'hF,1,0,0,1,16'd5});
    tbl.push_back('{0,0,0,0,0,16'd0,4'hF,4'hF, 4'hF,1,0,0,1,16'd6});
    tbl.push_back('{0,0,0,0,0,16'd0,4'hF,4'hF, 4'hF,1,0,0,1,16'd7});
    tbl.push_back('{0,0,0,0,0,16'd0,4'hF,4'hF, 4'hF,0,0,1,1,16'd8});
    tbl.push_back('{0,0,0,0,1,16'd0,4'hF,4'hF, 4'h0,0,0,1,1,16'd8});
    tbl.push_back('{1,0,0,0,0,16'd2,4'hF,4'h0, 4'h0,1,0,0,0,16'd0});
    tbl.push_back('{0,0,0,0,0,16'd0,4'hF,4'hF, 4'hF,1,0,0,0,16'd1});
    tbl.push_back('{1,0,0,0,0,16'd5,4'hF,4'hF, 4'hF,0,0,1,0,16'd2});
    tbl.push_back('{0,0,0,0,1,16'd0,4'hF,4'hF, 4'h0,0,0,1,0,16'd2});
    tbl.push_back('{1,1,0,0,0,16'd7,4'hF,4'hF, 4'h0,0,0,1,0,16'd2});
    tbl.push_back('{1,1,1,0,0,16'd7,4'hF,4'hF, 4'h0,0,0,1,0,16'd2});
    tbl.push_back('{0,0,0,0,0,16'd0,4'hF,4'hF, 4'h0,0,0,1,0,16'd2});
    tbl.push_back('{0,0,0,0,1,16'd0,4'hF,4'hF, 4'h0,0,0,1,0,16'd2});

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].arm, tbl[i].abort, tbl[i].tmode, tbl[i].trig, tbl[i].dovf,
           tbl[i].len, tbl[i].en, tbl[i].vin, mk_data(i));
      chk_status($sformatf("vec%0d", i), tbl[i].e_vout, tbl[i].e_busy,
                 tbl[i].e_armed, tbl[i].e_done, tbl[i].e_ovf, tbl[i].e_cnt);
      chk($sformatf("vec%0d_data", i), bus_if.adc_data_out, mk_data(i));
    end

    // Trigger mode, length 4, trigger already high at arm
    step(1, 0, 1, 1, 0, 16'd4, 4'hF, 4'hF, 128'h0);
    chk_status("trig_arm", 4'h0, 1, 1, 0, 0, 16'd0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 1, 0, 16'd0, 4'hF, 4'hF, 128'h0);
      chk_status("trig_held", 4'h0, 1, 1, 0, 0, 16'd0);
    end
    step(0, 0, 0, 0, 0, 16'd0, 4'hF, 4'hF, 128'h0);
    chk_status("trig_low", 4'h0, 1, 1, 0, 0, 16'd0);
    step(0, 0, 0, 1, 0, 16'd0, 4'hF, 4'hF, 128'h0);
    chk_status("trig_edge", 4'h0, 1, 0, 0, 0, 16'd0);
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 0, 1, 0, 16'd0, 4'hF, 4'hF, 128'h0);
      chk_status($sformatf("trig_beat%0d", k), 4'hF, (k != 4), 0, (k == 4), 0, 16'(k));
    end
    step(0, 0, 0, 1, 0, 16'd0, 4'hF, 4'hF, 128'h0);
    chk_status("trig_after", 4'h0, 0, 0, 1, 0, 16'd4);

    // Length 16 with sparse and non-qualifying valids, enable 0101
    step(1, 0, 0, 0, 0, 16'd16, 4'b0101, 4'h0, 128'h0);
    chk_status("sparse_arm", 4'h0, 1, 0, 0, 0, 16'd0);
    cnt = 0; cap = 1'b1; done = 1'b0;
    for (int i = 0; i < 36; i++) begin
      case (i % 4)
        0, 2:    vin = 4'b1111;
        1:       vin = 4'b0000;
        default: vin = 4'b1010;
      endcase
      ev = cap ? (vin & 4'b0101) : 4'h0;
      if (cap && ((vin & 4'b0101) != 4'h0)) begin
        cnt++;
        if (cnt == 16) begin
          cap = 1'b0;
          done = 1'b1;
        end
      end
      step(0, 0, 0, 0, 0, 16'd0, 4'b0101, vin, 128'h0);
      chk_status($sformatf("sparse%0d", i), ev, cap, 0, done, 0, 16'(cnt));
    end

    // Continuous mode, saturation and abort
    step(1, 0, 0, 0, 0, 16'd0, 4'hF, 4'h0, 128'h0);
    chk_status("cont_arm", 4'h0, 1, 0, 0, 0, 16'd0);
    for (int i = 0; i < 70000; i++) begin
      step(0, 0, 0, 0, 0, 16'd0, 4'hF, 4'hF, 128'h0);
      if (i == 65533) chk("cont_cnt_fffe", {112'd0, bus_if.status_beat_count}, {112'd0, 16'hFFFE});
    end
    chk_status("cont_sat", 4'hF, 1, 0, 0, 0, 16'hFFFF);
    step(0, 1, 0, 0, 0, 16'd0, 4'hF, 4'h0, 128'h0);
    chk_status("cont_abort", 4'h0, 0, 0, 0, 0, 16'hFFFF);
    step(0, 0, 0, 0, 0, 16'd0, 4'hF, 4'hF, 128'h0);
    chk_status("cont_idle", 4'h0, 0, 0, 0, 0, 16'hFFFF);

    // Abort coinciding with the final beat
    step(1, 0, 0, 0, 0, 16'd2, 4'hF, 4'h0, 128'h0);
    chk_status("abfin_arm", 4'h0, 1, 0, 0, 0, 16'd0);
    step(0, 0, 0, 0, 0, 16'd0, 4'hF, 4'hF, 128'h0);
    chk_status("abfin_b1", 4'hF, 1, 0, 0, 0, 16'd1);
    step(0, 1, 0, 0, 0, 16'd0, 4'hF, 4'hF, 128'h0);
    chk("abfin_vout", {124'd0, bus_if.adc_valid_out}, {124'd0, 4'hF});
    chk("abfin_done", {127'd0, bus_if.status_done}, 128'd0);
    chk("abfin_busy", {127'd0, bus_if.status_busy}, 128'd0);
    step(0, 0, 0, 0, 0, 16'd0, 4'hF, 4'hF, 128'h0);
    chk("abfin_after_vout", {124'd0, bus_if.adc_valid_out}, 128'd0);
    chk("abfin_after_done", {127'd0, bus_if.status_done}, 128'd0);

    // Asynchronous reset in the middle of a capture
    step(1, 0, 0, 0, 1, 16'd10, 4'hF, 4'h0, mk_data(100));
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1, 16'd0, 4'hF, 4'hF, mk_data(101 + k));
    chk_status("prerst", 4'hF, 1, 0, 0, 1, 16'd3);
    #2;
    rst = 1'b1;
    #1;
    chk_status("midrst", 4'h0, 0, 0, 0, 0, 16'd0);
    chk("midrst_data", bus_if.adc_data_out, 128'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(0, 0, 0, 0, 0, 16'd0, 4'hF, 4'hF, mk_data(200));
    chk_status("postrst", 4'h0, 0, 0, 0, 0, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
